// File: rtl/ahb_csr_bridge_if.sv
// AHB-Lite slave port plus CSR request port of the AHB-to-CSR bridge.
// slave = bridge view, master = environment (AHB master + CSR target) view.
interface ahb_csr_bridge_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              hselx;
  logic              hready;
  logic [31:0]       haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic [31:0]       hwdata;
  logic [31:0]       hrdata;
  logic              hready_out;
  logic              hresp;

  logic              csr_req;
  logic              csr_wr;
  logic [ADDR_W-1:0] csr_addr;
  logic [31:0]       csr_wdata;
  logic [3:0]        csr_wstrb;
  logic [31:0]       csr_rdata;
  logic              csr_ack;
  logic              csr_err;

  modport slave (
    input  hselx, hready, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
    output hrdata, hready_out, hresp,
    output csr_req, csr_wr, csr_addr, csr_wdata, csr_wstrb,
    input  csr_rdata, csr_ack, csr_err
  );

  modport master (
    output hselx, hready, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
    input  hrdata, hready_out, hresp,
    input  csr_req, csr_wr, csr_addr, csr_wdata, csr_wstrb,
    output csr_rdata, csr_ack, csr_err
  );
endinterface

// File: rtl/ahb_csr_bridge.sv
// AHB-Lite slave that turns each legal transfer into one CSR request/ack
// handshake, with a bounded wait and the two-cycle AHB ERROR response.
module ahb_csr_bridge #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  ahb_csr_bridge_if.slave    bus
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;

  logic              sample_c;
  logic              illegal_c;
  logic [3:0]        lanes_c;
  logic [ADDR_W-1:0] addr_c;

  // Address-phase decode: accept, legality, write lanes, word-aligned address.
  always_comb begin
    sample_c  = bus.hselx & bus.hready & bus.htrans[1];
    illegal_c = 1'b0;
    if (bus.hsize > 3'd2)                               illegal_c = 1'b1;
    if ((bus.hsize == 3'd1) && bus.haddr[0])            illegal_c = 1'b1;
    if ((bus.hsize == 3'd2) && (bus.haddr[1:0] != 2'b00)) illegal_c = 1'b1;
    if ((bus.haddr >> ADDR_W) != 32'd0)                 illegal_c = 1'b1;

    lanes_c = 4'b0000;
    if (bus.hwrite) begin
      case (bus.hsize)
        3'd0:    lanes_c = 4'b0001 << bus.haddr[1:0];
        3'd1:    lanes_c = 4'b0011 << {bus.haddr[1], 1'b0};
        default: lanes_c = 4'b1111;
      endcase
    end

    addr_c = bus.haddr[ADDR_W-1:0] & ~ADDR_W'(3);
  end

  // Write data is only valid on the bus during the data phase, so it is passed through.
  assign bus.csr_wdata = ((state == S_ACCESS) && bus.csr_wr) ? bus.hwdata : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      bus.hready_out <= 1'b1;
      bus.hresp      <= 1'b0;
      bus.hrdata     <= 32'd0;
      bus.csr_req    <= 1'b0;
      bus.csr_wr     <= 1'b0;
      bus.csr_addr   <= '0;
      bus.csr_wstrb  <= 4'b0000;
    end else begin
      case (state)
        S_ACCESS: begin
          if (bus.csr_ack) begin
            bus.csr_req <= 1'b0;
            if (bus.csr_err) begin
              state     <= S_ERR1;
              bus.hresp <= 1'b1;
            end else begin
              state          <= S_DONE;
              bus.hready_out <= 1'b1;
              if (!bus.csr_wr) bus.hrdata <= bus.csr_rdata;
            end
          end else if (cnt == CNT_LAST) begin
            bus.csr_req <= 1'b0;
            state       <= S_ERR1;
            bus.hresp   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_ERR1: begin
          state          <= S_ERR2;
          bus.hready_out <= 1'b1;
          bus.hresp      <= 1'b1;
        end

        // IDLE, DONE and ERR2 all accept a pipelined address phase.
        default: begin
          if (sample_c && illegal_c) begin
            state          <= S_ERR1;
            bus.hready_out <= 1'b0;
            bus.hresp      <= 1'b1;
            bus.csr_req    <= 1'b0;
          end else if (sample_c) begin
            state          <= S_ACCESS;
            cnt            <= '0;
            bus.hready_out <= 1'b0;
            bus.hresp      <= 1'b0;
            bus.csr_req    <= 1'b1;
            bus.csr_wr     <= bus.hwrite;
            bus.csr_addr   <= addr_c;
            bus.csr_wstrb  <= lanes_c;
          end else begin
            state          <= S_IDLE;
            bus.hready_out <= 1'b1;
            bus.hresp      <= 1'b0;
          end
        end
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.hburst, bus.hprot, bus.htrans[0]};

endmodule

// File: tb/tb_ahb_csr_bridge.sv
// Directed bench for ahb_csr_bridge: single AHB master with hready looped back
// from hready_out, CSR target modelled by directly driven ack/err/rdata.
module tb_ahb_csr_bridge;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ahb_csr_bridge_if #(.ADDR_W(ADDR_W)) bus ();
  assign bus.hready = bus.hready_out;

  ahb_csr_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz);
    bus.hselx  = 1'b1;
    bus.htrans = 2'd2;
    bus.haddr  = a;
    bus.hwrite = w;
    bus.hsize  = sz;
  endtask

  task automatic bus_idle();
    bus.hselx  = 1'b0;
    bus.htrans = 2'd0;
  endtask

  logic [31:0] bad_addr [3];
  logic [2:0]  bad_size [3];

  initial begin
    int hi;
    rst           = 1'b1;
    bus.hselx     = 1'b0;
    bus.htrans    = 2'd0;
    bus.haddr     = 32'd0;
    bus.hwrite    = 1'b0;
    bus.hsize     = 3'd0;
    bus.hburst    = 3'd3;
    bus.hprot     = 4'h3;
    bus.hwdata    = 32'd0;
    bus.csr_rdata = 32'd0;
    bus.csr_ack   = 1'b0;
    bus.csr_err   = 1'b0;
    bad_addr[0] = 32'h0000_0002; bad_size[0] = 3'd2;
    bad_addr[1] = 32'h0001_0000; bad_size[1] = 3'd2;
    bad_addr[2] = 32'h0000_0000; bad_size[2] = 3'd3;

    // Reset values
    repeat (2) step();
    check("rst_hready", 32'(bus.hready_out), 32'd1);
    check("rst_hresp",  32'(bus.hresp),      32'd0);
    check("rst_hrdata", bus.hrdata,          32'd0);
    check("rst_req",    32'(bus.csr_req),    32'd0);
    check("rst_wr",     32'(bus.csr_wr),     32'd0);
    check("rst_addr",   32'(bus.csr_addr),   32'd0);
    check("rst_wstrb",  32'(bus.csr_wstrb),  32'd0);
    rst = 1'b0;

    // Word write, ack in first ACCESS cycle
    addr_phase(32'h0000_0010, 1'b1, 3'd2);
    mid();
    check("w_idle_rdy", 32'(bus.hready_out), 32'd1);
    step();
    bus_idle();
    bus.hwdata    = 32'hDEAD_BEEF;
    bus.csr_rdata = 32'h55AA_55AA;
    bus.csr_ack   = 1'b1;
    mid();
    check("w_req",   32'(bus.csr_req),    32'd1);
    check("w_wr",    32'(bus.csr_wr),     32'd1);
    check("w_addr",  32'(bus.csr_addr),   32'h10);
    check("w_wstrb", 32'(bus.csr_wstrb),  32'hF);
    check("w_wdata", bus.csr_wdata,       32'hDEAD_BEEF);
    check("w_wait",  32'(bus.hready_out), 32'd0);
    step();
    bus.csr_ack = 1'b0;
    bus.hwdata  = 32'd0;
    mid();
    check("w_done_req",  32'(bus.csr_req),    32'd0);
    check("w_done_rdy",  32'(bus.hready_out), 32'd1);
    check("w_done_resp", 32'(bus.hresp),      32'd0);
    check("w_hrdata",    bus.hrdata,          32'd0);
    step();

    // Byte read at 0x13, ack in third ACCESS cycle
    addr_phase(32'h0000_0013, 1'b0, 3'd0);
    bus.hwdata = 32'hFFFF_FFFF;
    step();
    bus_idle();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        bus.csr_ack   = 1'b1;
        bus.csr_rdata = 32'h1122_3344;
      end
      mid();
      check("r_req",   32'(bus.csr_req),    32'd1);
      check("r_wait",  32'(bus.hready_out), 32'd0);
      check("r_wstrb", 32'(bus.csr_wstrb),  32'd0);
      check("r_addr",  32'(bus.csr_addr),   32'h10);
      check("r_wdata", bus.csr_wdata,       32'd0);
      step();
    end
    bus.csr_ack   = 1'b0;
    bus.csr_rdata = 32'd0;
    mid();
    check("r_hrdata", bus.hrdata,          32'h1122_3344);
    check("r_rdy",    32'(bus.hready_out), 32'd1);
    check("r_resp",   32'(bus.hresp),      32'd0);
    check("r_req_lo", 32'(bus.csr_req),    32'd0);
    step();

    // Illegal transfers: unaligned, out of range, oversize
    for (int k = 0; k < 3; k++) begin
      addr_phase(bad_addr[k], 1'b0, bad_size[k]);
      step();
      bus_idle();
      mid();
      check("ill_e1_req",  32'(bus.csr_req),    32'd0);
      check("ill_e1_rdy",  32'(bus.hready_out), 32'd0);
      check("ill_e1_resp", 32'(bus.hresp),      32'd1);
      step();
      mid();
      check("ill_e2_rdy",  32'(bus.hready_out), 32'd1);
      check("ill_e2_resp", 32'(bus.hresp),      32'd1);
      check("ill_e2_req",  32'(bus.csr_req),    32'd0);
      step();
    end
    check("ill_hrdata", bus.hrdata, 32'h1122_3344);

    // Timeout: no ack for TIMEOUT cycles, late ack ignored
    addr_phase(32'h0000_0020, 1'b0, 3'd2);
    step();
    bus_idle();
    hi = 0;
    for (int i = 0; i < 15; i++) begin
      mid();
      if (bus.csr_req === 1'b1) hi++;
      step();
    end
    check("to_req_cycles", 32'(hi), 32'd15);
    bus.csr_ack   = 1'b1;
    bus.csr_rdata = 32'hBAD0_BAD0;
    mid();
    check("to_e1_req",  32'(bus.csr_req),    32'd0);
    check("to_e1_rdy",  32'(bus.hready_out), 32'd0);
    check("to_e1_resp", 32'(bus.hresp),      32'd1);
    step();
    mid();
    check("to_e2_rdy",  32'(bus.hready_out), 32'd1);
    check("to_e2_resp", 32'(bus.hresp),      32'd1);
    step();
    mid();
    check("to_late_hrdata", bus.hrdata,          32'h1122_3344);
    check("to_late_req",    32'(bus.csr_req),    32'd0);
    check("to_idle_resp",   32'(bus.hresp),      32'd0);
    bus.csr_ack   = 1'b0;
    bus.csr_rdata = 32'd0;
    step();

    // Back-to-back halfword writes, second address sampled in DONE
    addr_phase(32'h0000_0002, 1'b1, 3'd1);
    step();
    addr_phase(32'h0000_0004, 1'b1, 3'd1);
    bus.hwdata  = 32'hAAAA_0000;
    bus.csr_ack = 1'b1;
    mid();
    check("b2b1_req",   32'(bus.csr_req),   32'd1);
    check("b2b1_wstrb", 32'(bus.csr_wstrb), 32'hC);
    check("b2b1_addr",  32'(bus.csr_addr),  32'h0);
    check("b2b1_wdata", bus.csr_wdata,      32'hAAAA_0000);
    step();
    bus.csr_ack = 1'b0;
    mid();
    check("b2b_done_req", 32'(bus.csr_req),    32'd0);
    check("b2b_done_rdy", 32'(bus.hready_out), 32'd1);
    step();
    bus_idle();
    bus.hwdata  = 32'h0000_5555;
    bus.csr_ack = 1'b1;
    mid();
    check("b2b2_req",   32'(bus.csr_req),   32'd1);
    check("b2b2_wstrb", 32'(bus.csr_wstrb), 32'h3);
    check("b2b2_addr",  32'(bus.csr_addr),  32'h4);
    check("b2b2_wdata", bus.csr_wdata,      32'h0000_5555);
    step();
    bus.csr_ack = 1'b0;
    mid();
    check("b2b2_rdy",    32'(bus.hready_out), 32'd1);
    check("b2b2_resp",   32'(bus.hresp),      32'd0);
    check("b2b2_hrdata", bus.hrdata,          32'h1122_3344);
    step();

    // CSR error response on a write
    addr_phase(32'h0000_0040, 1'b1, 3'd2);
    step();
    bus_idle();
    bus.csr_ack = 1'b1;
    bus.csr_err = 1'b1;
    mid();
    check("cerr_req", 32'(bus.csr_req), 32'd1);
    step();
    bus.csr_ack = 1'b0;
    bus.csr_err = 1'b0;
    mid();
    check("cerr_e1_rdy",  32'(bus.hready_out), 32'd0);
    check("cerr_e1_resp", 32'(bus.hresp),      32'd1);
    check("cerr_e1_req",  32'(bus.csr_req),    32'd0);
    step();
    mid();
    check("cerr_e2_rdy",  32'(bus.hready_out), 32'd1);
    check("cerr_e2_resp", 32'(bus.hresp),      32'd1);
    step();

    // Reset in the middle of ACCESS, then a normal transfer
    addr_phase(32'h0000_0030, 1'b0, 3'd2);
    step();
    bus_idle();
    mid();
    check("rs_req_before", 32'(bus.csr_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rs_req",    32'(bus.csr_req),    32'd0);
    check("rs_rdy",    32'(bus.hready_out), 32'd1);
    check("rs_resp",   32'(bus.hresp),      32'd0);
    check("rs_hrdata", bus.hrdata,          32'd0);
    check("rs_wdata",  bus.csr_wdata,       32'd0);
    step();
    rst = 1'b0;
    addr_phase(32'h0000_0008, 1'b0, 3'd2);
    step();
    bus_idle();
    bus.csr_ack   = 1'b1;
    bus.csr_rdata = 32'hCAFE_F00D;
    mid();
    check("rs2_req",  32'(bus.csr_req),  32'd1);
    check("rs2_addr", 32'(bus.csr_addr), 32'h8);
    step();
    bus.csr_ack   = 1'b0;
    bus.csr_rdata = 32'd0;
    mid();
    check("rs2_hrdata", bus.hrdata,          32'hCAFE_F00D);
    check("rs2_rdy",    32'(bus.hready_out), 32'd1);
    check("rs2_resp",   32'(bus.hresp),      32'd0);
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
